imem_loader: RTL and testbench

//  Write-side counterpart of the instruction memory. Receives a byte stream from a host
//  (UART/JTAG bridge or testbench) over a valid/ready handshake and packs it little-endian

---
 rtl/imem_loader_pkg.sv | 6 +
 rtl/imem_loader_byte_packer.sv | 28 ++
 rtl/imem_loader.sv | 94 +++++++++
 tb/tb_imem_loader.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_pkg: instruction-memory geometry and loader state encoding shared by the loader files.
package imem_pkg;
   localparam int IMEM_DEPTH  = 32;
   localparam int IMEM_ADDR_W = $clog2(IMEM_DEPTH);
   typedef enum logic [1:0] {LD_IDLE, LD_COLLECT, LD_WRITE, LD_DONE} ld_state_e;
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: little-endian byte-to-word assembler; the 2-bit index wraps 3 -> 0 after a full word.
module byte_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   output logic        word_full_o,
   output logic [31:0] word_o
);
   logic [31:0] word_q, word_d;
   logic [1:0]  idx_q, idx_d;
   always_comb begin
      word_d = word_q;
      if (accept_i) word_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d = accept_i ? idx_q + 2'd1 : idx_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end
   assign word_full_o = accept_i && idx_q == 2'd3;
   assign word_o      = word_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a host byte stream into 32-bit words, writes them from address 0, stalls the core until loaded.
// Optional IMEM_LOADER_CHECKSUM_EN adds csum, the XOR of all words written in the current load.
module imem_loader
   import imem_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W:0]   word_count,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              cpu_stall
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic [31:0]       csum
`endif
);
   localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
   ld_state_e         state_q, state_d;
   logic [ADDR_W:0]   target_q, target_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              stall_q, stall_d;
   logic              word_full, last_word, accept_start;
   assign accept_start = state_q == LD_IDLE && start;
   assign last_word    = (ADDR_W+1)'(addr_q) + (ADDR_W+1)'(1) >= target_q;
   byte_packer u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .accept_i    (byte_valid && byte_ready),
      .byte_i      (byte_data),
      .word_full_o (word_full),
      .word_o      (wr_data)
   );
   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      addr_d   = addr_q;
      stall_d  = stall_q;
      case (state_q)
         LD_IDLE: if (start) begin
            target_d = word_count > DEPTH_W ? DEPTH_W : word_count;
            addr_d   = '0;
            state_d  = word_count == '0 ? LD_DONE : LD_COLLECT;
            stall_d  = word_count != '0;
         end
         LD_COLLECT: state_d = word_full ? LD_WRITE : LD_COLLECT;
         LD_WRITE: begin
            state_d = last_word ? LD_DONE : LD_COLLECT;
            stall_d = !last_word && stall_q;
            addr_d  = last_word ? addr_q : addr_q + ADDR_W'(1);
         end
         default: state_d = LD_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= LD_IDLE;
         target_q <= '0;
         addr_q   <= '0;
         stall_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         addr_q   <= addr_d;
         stall_q  <= stall_d;
      end
   end
   assign byte_ready = state_q == LD_COLLECT;
   assign wr_en      = state_q == LD_WRITE;
   assign wr_addr    = addr_q;
   assign busy       = state_q == LD_COLLECT || state_q == LD_WRITE;
   assign done       = state_q == LD_DONE;
   assign cpu_stall  = stall_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] csum_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) csum_q <= '0;
      else csum_q <= accept_start ? '0 : wr_en ? csum_q ^ wr_data : csum_q;
   end
   assign csum = csum_q;
`else
   logic unused_start;
   assign unused_start = accept_start;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven and hand-written load sequences against a word-list reference model.
module tb_imem_loader;
   logic        clk = 0, rst_n, start, byte_valid, byte_ready, wr_en, busy, done, cpu_stall;
   logic [5:0]  word_count;
   logic [7:0]  byte_data;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] csum;
`endif
   imem_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .done(done), .cpu_stall(cpu_stall)
`ifdef IMEM_LOADER_CHECKSUM_EN
      , .csum(csum)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;
   typedef struct {int wc; int gap; int exp_n;} vec_t;
   wr_t         wq[$];
   logic [31:0] words[64];
   int          n_chk = 0, n_fail = 0, tot_wr = 0, exp_total = 0;
   always @(negedge clk) if (wr_en) begin
      wq.push_back('{wr_addr, wr_data});
      tot_wr++;
   end
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   task automatic send_byte(input logic [7:0] b, input int gap);
      int guard = 0;
      bit sent = 0;
      while (!sent) begin
         @(posedge clk); #1;
         byte_valid = $urandom_range(0, 99) >= gap;
         byte_data  = b;
         @(negedge clk);
         sent = byte_valid && byte_ready;
         if (++guard > 300) begin
            $display("FAIL byte_handshake_timeout: got no ready, expected ready");
            $fatal(1);
         end
      end
   endtask
   task automatic start_load(input int wc);
      @(posedge clk); #1;
      start = 1; word_count = 6'(wc);
      @(posedge clk); #1;
      start = 0;
   endtask
   task automatic run_load(input int wc, input int gap, input int exp_n, input bit poke);
      int n = wc > 32 ? 32 : wc;
      int guard = 0;
      logic [31:0] x = 0;
      wq.delete();
      start_load(wc);
      chk("stall_on_start", cpu_stall, 1);
      chk("busy_on_start", busy, 1);
      for (int i = 0; i < n; i++) for (int k = 0; k < 4; k++) begin
         if (poke && i == 0 && k == 2) begin
            start = 1; word_count = 6'd5;
            @(posedge clk); #1;
            start = 0; byte_valid = 0;
         end
         send_byte(words[i][8*k +: 8], gap);
      end
      @(posedge clk); #1;
      byte_valid = 0;
      while (!done && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      chk("done_seen", done, 1);
      chk("stall_at_done", cpu_stall, 0);
      chk("busy_at_done", busy, 0);
      for (int i = 0; i < n; i++) x ^= words[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("csum", csum, x);
`endif
      if (poke) start = 1;
      @(posedge clk); #1;
      start = 0;
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
      chk($sformatf("write_count_wc%0d", wc), wq.size(), exp_n);
      for (int i = 0; i < wq.size() && i < n; i++) begin
         chk($sformatf("wr_addr_%0d", i), wq[i].a, i);
         chk($sformatf("wr_data_%0d", i), wq[i].d, words[i]);
      end
      exp_total += n;
   endtask
   vec_t vt[5];
   initial begin
      vt = '{'{3, 40, 3}, '{5, 25, 5}, '{40, 15, 32}, '{33, 0, 32}, '{32, 30, 32}};
      rst_n = 0; start = 0; word_count = 0; byte_valid = 0; byte_data = 0;
      repeat (2) @(negedge clk);
      chk("rst_byte_ready", byte_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cpu_stall", cpu_stall, 1);
      @(posedge clk); #1;
      rst_n = 1;
      words[0] = 32'h00000013;
      run_load(1, 0, 1, 0);
      words[0] = 32'h0062e233; words[1] = 32'h0064a423; words[2] = 32'h01498933;
      run_load(3, 50, 3, 0);
      words[0] = 32'h0000000F; words[1] = 32'h000000F0;
      run_load(2, 20, 2, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk("csum_hold_ff", csum, 32'h000000FF);
`endif
      wq.delete();
      start_load(0);
      chk("stall_zero_wc", cpu_stall, 0);
      @(negedge clk);
      chk("zero_done", done, 1);
      @(negedge clk);
      chk("zero_done_one_cycle", done, 0);
      chk("zero_no_write", wq.size(), 0);
      foreach (vt[j]) begin
         for (int i = 0; i < 64; i++) words[i] = $urandom;
         run_load(vt[j].wc, vt[j].gap, vt[j].exp_n, 0);
      end
      wq.delete();
      words[0] = $urandom; words[1] = $urandom;
      start_load(2);
      for (int i = 0; i < 6; i++) send_byte(words[i / 4][8*(i % 4) +: 8], 30);
      @(posedge clk); #1;
      rst_n = 0; byte_valid = 0;
      #1;
      chk("abort_wr_en", wr_en, 0);
      chk("abort_byte_ready", byte_ready, 0);
      chk("abort_wr_addr", wr_addr, 0);
      chk("abort_busy", busy, 0);
      chk("abort_stall", cpu_stall, 1);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      rst_n = 1;
      repeat (4) @(negedge clk);
      chk("abort_write_count", wq.size(), 1);
      chk("abort_first_word", wq.size() > 0 ? wq[0].d : 32'hx, words[0]);
      chk("abort_addr_after", wr_addr, 0);
      exp_total += 1;
      for (int i = 0; i < 64; i++) words[i] = $urandom;
      run_load(4, 10, 4, 0);
      repeat (3) @(negedge clk);
      chk("total_writes", tot_wr, exp_total);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
